// File: rtl/mips_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_bus_pkg
//  Purpose  : Shared types and widths for the CPU memory-bus arbiter slice.
//             Holds the arbiter state encoding and the default bus widths.
//  Contents : arb_state_t  - arbiter FSM states {IDLE, ACCESS, LAT, DONE}
//             BUS_ADDR_W   - default byte address width
//             BUS_DATA_W   - default data width
//             BUS_BE_W     - default byte-enable width
//  Revision : 1.0  initial release
// ============================================================================
package mips_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_BE_W   = BUS_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    LAT    = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

endpackage : mips_bus_pkg
`default_nettype wire

// File: rtl/mips_bus_grant_sel.sv
`default_nettype none
// ============================================================================
//  Module   : mips_bus_grant_sel
//  Purpose  : Combinational two-way grant selector for the bus arbiter.
//             MIPS_BUS_ARB_RR_EN defined  : round-robin, the last-granted
//                                           master loses a simultaneous tie.
//             MIPS_BUS_ARB_RR_EN undefined: fixed priority, master 0 wins.
//  Ports    : i_req[1:0]    per-master request (read | write)
//             i_last_grant  index of the most recently granted master
//             o_grant       selected master index
//             o_valid       at least one request present
//  Revision : 1.0  initial release
// ============================================================================
module mips_bus_grant_sel (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant,
  output logic       o_valid
);

  assign o_valid = |i_req;

`ifdef MIPS_BUS_ARB_RR_EN
  always_comb begin
    // With no request the index is a don't-care; hold the pointer value.
    o_grant = i_last_grant;
    if (i_req == 2'b11) begin
      o_grant = ~i_last_grant;
    end else if (i_req[0]) begin
      o_grant = 1'b0;
    end else if (i_req[1]) begin
      o_grant = 1'b1;
    end
  end
`else
  always_comb begin
    // Pointer only feeds the don't-care (no request) case in this mode.
    o_grant = i_last_grant;
    if (i_req[0]) begin
      o_grant = 1'b0;
    end else if (i_req[1]) begin
      o_grant = 1'b1;
    end
  end
`endif

endmodule : mips_bus_grant_sel
`default_nettype wire

// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mips_bus_arbiter
//  Purpose  : Two-master / one-slave arbiter for the CPU memory bus.
//             Master 0 is the CPU port, master 1 the loader/debug port. One
//             command is latched in IDLE, issued in ACCESS, optionally waits
//             out the slave read latency in LAT, and is acknowledged to the
//             granted master for one cycle in DONE. All outputs registered.
//  Config   : MIPS_BUS_ARB_RR_EN - round-robin arbitration when defined,
//             fixed priority (master 0 first) otherwise.
//  Ports    : clk, reset (async, active low)
//             m_address/m_read/m_write/m_writedata/m_byteenable  master cmd
//             m_waitrequest[1:0], m_readdata                     master resp
//             s_address/s_read/s_write/s_writedata/s_byteenable  slave cmd
//             s_waitrequest, s_readdata                          slave resp
//             busy - high whenever the FSM is not in IDLE
//  Revision : 1.0  initial release
// ============================================================================
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W       = BUS_ADDR_W,
  parameter int DATA_W       = BUS_DATA_W,
  parameter int READ_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0][ADDR_W-1:0]     m_address,
  input  logic [1:0]                 m_read,
  input  logic [1:0]                 m_write,
  input  logic [1:0][DATA_W-1:0]     m_writedata,
  input  logic [1:0][DATA_W/8-1:0]   m_byteenable,
  output logic [1:0]                 m_waitrequest,
  output logic [DATA_W-1:0]          m_readdata,
  output logic [ADDR_W-1:0]          s_address,
  output logic                       s_read,
  output logic                       s_write,
  output logic [DATA_W-1:0]          s_writedata,
  output logic [DATA_W/8-1:0]        s_byteenable,
  input  logic                       s_waitrequest,
  input  logic [DATA_W-1:0]          s_readdata,
  output logic                       busy
);

  localparam int         BE_W       = DATA_W / 8;
  // Counter start value for LAT; unused when READ_LATENCY is 0.
  localparam logic [2:0] c_LAT_INIT = (READ_LATENCY == 0) ? 3'd0
                                                          : 3'(READ_LATENCY - 1);

  arb_state_t          r_state;
  logic                r_grant;
  logic                r_last_grant;
  logic                r_op_write;
  logic [2:0]          r_lat_cnt;
  logic [1:0]          r_m_waitrequest;
  logic [DATA_W-1:0]   r_m_readdata;
  logic [ADDR_W-1:0]   r_s_address;
  logic                r_s_read;
  logic                r_s_write;
  logic [DATA_W-1:0]   r_s_writedata;
  logic [BE_W-1:0]     r_s_byteenable;
  logic                r_busy;

  logic [1:0]          w_req;
  logic                w_grant;
  logic                w_valid;

  assign w_req = m_read | m_write;

  mips_bus_grant_sel u_grant_sel (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_valid      (w_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_grant         <= 1'b0;
      r_last_grant    <= 1'b1;   // master 0 wins the first tie
      r_op_write      <= 1'b0;
      r_lat_cnt       <= 3'd0;
      r_m_waitrequest <= 2'b11;
      r_m_readdata    <= '0;
      r_s_address     <= '0;
      r_s_read        <= 1'b0;
      r_s_write       <= 1'b0;
      r_s_writedata   <= '0;
      r_s_byteenable  <= '0;
      r_busy          <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_m_waitrequest <= 2'b11;
          if (w_valid) begin
            r_grant        <= w_grant;
            r_last_grant   <= w_grant;
            r_op_write     <= m_write[w_grant];
            r_s_address    <= m_address[w_grant];
            r_s_writedata  <= m_writedata[w_grant];
            r_s_byteenable <= m_byteenable[w_grant];
            // A master raising both strobes gets the write; the read is dropped.
            r_s_write      <= m_write[w_grant];
            r_s_read       <= m_read[w_grant] & ~m_write[w_grant];
            r_busy         <= 1'b1;
            r_state        <= ACCESS;
          end
        end

        ACCESS: begin
          if (!s_waitrequest) begin
            r_s_read  <= 1'b0;
            r_s_write <= 1'b0;
            if (r_op_write) begin
              r_m_waitrequest[r_grant] <= 1'b0;
              r_state                  <= DONE;
            end else if (READ_LATENCY == 0) begin
              r_m_readdata             <= s_readdata;
              r_m_waitrequest[r_grant] <= 1'b0;
              r_state                  <= DONE;
            end else begin
              r_lat_cnt <= c_LAT_INIT;
              r_state   <= LAT;
            end
          end
        end

        LAT: begin
          if (r_lat_cnt == 3'd0) begin
            r_m_readdata             <= s_readdata;
            r_m_waitrequest[r_grant] <= 1'b0;
            r_state                  <= DONE;
          end else begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
          end
        end

        DONE: begin
          // Acknowledge lasts exactly this one cycle.
          r_m_waitrequest <= 2'b11;
          r_busy          <= 1'b0;
          r_state         <= IDLE;
        end

        default: begin
          r_m_waitrequest <= 2'b11;
          r_s_read        <= 1'b0;
          r_s_write       <= 1'b0;
          r_busy          <= 1'b0;
          r_state         <= IDLE;
        end
      endcase
    end
  end

  assign m_waitrequest = r_m_waitrequest;
  assign m_readdata    = r_m_readdata;
  assign s_address     = r_s_address;
  assign s_read        = r_s_read;
  assign s_write       = r_s_write;
  assign s_writedata   = r_s_writedata;
  assign s_byteenable  = r_s_byteenable;
  assign busy          = r_busy;

endmodule : mips_bus_arbiter
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_bus_arbiter
//  Purpose  : Self-checking bench for mips_bus_arbiter (READ_LATENCY = 1).
//             A behavioural RAM slave with programmable stall sits on the
//             slave port; expectations come from a vector table, hand-written
//             arbitration/reset sequences and a word-array memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_bus_arbiter;

  localparam int RL = 1;

  logic              clk;
  logic              reset;
  logic [1:0][31:0]  m_address;
  logic [1:0]        m_read;
  logic [1:0]        m_write;
  logic [1:0][31:0]  m_writedata;
  logic [1:0][3:0]   m_byteenable;
  logic [1:0]        m_waitrequest;
  logic [31:0]       m_readdata;
  logic [31:0]       s_address;
  logic              s_read;
  logic              s_write;
  logic [31:0]       s_writedata;
  logic [3:0]        s_byteenable;
  logic              s_waitrequest;
  logic [31:0]       s_readdata;
  logic              busy;

  int checks = 0;
  int errors = 0;

  mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(RL)) dut (
    .clk           (clk),
    .reset         (reset),
    .m_address     (m_address),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_byteenable  (m_byteenable),
    .m_waitrequest (m_waitrequest),
    .m_readdata    (m_readdata),
    .s_address     (s_address),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_writedata   (s_writedata),
    .s_byteenable  (s_byteenable),
    .s_waitrequest (s_waitrequest),
    .s_readdata    (s_readdata),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- slave RAM with programmable stall ----------------
  logic [31:0] mem [0:1023];
  logic [31:0] rdata_q = 32'h0;
  int          stall_req = 0;
  int          stall_seen = 0;
  logic        strobe;

  assign strobe        = s_read | s_write;
  assign s_waitrequest = strobe && (stall_seen < stall_req);
  assign s_readdata    = rdata_q;

  always @(posedge clk) begin
    if (strobe && !s_waitrequest) begin
      if (s_write) begin
        for (int b = 0; b < 4; b++)
          if (s_byteenable[b]) mem[s_address[11:2]][b*8 +: 8] <= s_writedata[b*8 +: 8];
      end else begin
        rdata_q <= mem[s_address[11:2]];
      end
    end
    if (strobe && s_waitrequest) stall_seen <= stall_seen + 1;
    else if (!strobe)            stall_seen <= 0;
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:1023];
  logic [31:0] last_rd;

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One transaction from master m, request held until acknowledged.
  task automatic do_txn(input int m, input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int stall,
                        input int exp_cyc, input logic [31:0] exp_rd, input string name);
    int cyc;
    bit done;
    @(negedge clk);
    stall_req       = stall;
    m_address[m]    = addr;
    m_writedata[m]  = wdata;
    m_byteenable[m] = be;
    m_write[m]      = wr;
    m_read[m]       = rd;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (m_waitrequest[m] == 1'b0) done = 1'b1;
      else if (s_waitrequest)
        chk({name, " stalled cmd"}, {30'd0, s_write, s_read, s_address},
            {30'd0, wr, rd & ~wr, addr});
    end
    m_read[m]  = 1'b0;
    m_write[m] = 1'b0;
    chk({name, " cycle"}, 64'(cyc), 64'(exp_cyc));
    if (done) begin
      chk({name, " rdata"}, {32'd0, m_readdata}, {32'd0, exp_rd});
      chk({name, " other wait"}, {63'd0, m_waitrequest[1-m]}, 64'd1);
      @(negedge clk);
      chk({name, " ack width"}, {62'd0, m_waitrequest}, 64'd3);
    end
    stall_req = 0;
    if (wr) ref_mem[addr[11:2]] = merge_be(ref_mem[addr[11:2]], wdata, be);
    else    last_rd = ref_mem[addr[11:2]];
  endtask

  typedef struct {
    int          m;
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          stall;
    int          exp_cyc;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got0, got1, cyc, n, exp_g, model_last;
    int order [4];
    logic [31:0] exp_word;

    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    mem[4]     = 32'hDEAD_BEEF;  ref_mem[4] = 32'hDEAD_BEEF;
    mem[8]     = 32'hAABB_CCDD;  ref_mem[8] = 32'hAABB_CCDD;
    last_rd    = 32'h0;

    m_address = '0; m_read = '0; m_write = '0; m_writedata = '0; m_byteenable = '0;

    // -------- reset, then idle --------
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle state", {m_waitrequest, s_read, s_write, busy, m_readdata, s_address[26:0]},
          {2'b11, 1'b0, 1'b0, 1'b0, 32'h0, 27'h0});
    end

    // -------- vector table --------
    vecs[0] = '{0, 1'b0, 1'b1, 32'h10, 32'h0,         4'hF, 0, 3, 32'hDEAD_BEEF};
    vecs[1] = '{1, 1'b1, 1'b0, 32'h20, 32'h1234_5678, 4'h3, 0, 2, 32'hDEAD_BEEF};
    vecs[2] = '{1, 1'b0, 1'b1, 32'h20, 32'h0,         4'hF, 0, 3, 32'hAABB_5678};
    vecs[3] = '{0, 1'b1, 1'b0, 32'h30, 32'hCAFE_F00D, 4'hF, 4, 6, 32'hAABB_5678};
    vecs[4] = '{0, 1'b0, 1'b1, 32'h30, 32'h0,         4'hF, 0, 3, 32'hCAFE_F00D};
    vecs[5] = '{0, 1'b1, 1'b1, 32'h40, 32'h1111_2222, 4'hC, 0, 2, 32'hCAFE_F00D};
    vecs[6] = '{1, 1'b0, 1'b1, 32'h40, 32'h0,         4'hF, 0, 3, 32'h1111_0000};
    vecs[7] = '{0, 1'b0, 1'b1, 32'h10, 32'h0,         4'hF, 2, 5, 32'hDEAD_BEEF};
    for (int i = 0; i < 8; i++)
      do_txn(vecs[i].m, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].be,
             vecs[i].stall, vecs[i].exp_cyc, vecs[i].exp_rd, $sformatf("vec%0d", i));

    // -------- simultaneous reads from fresh reset: M0 first, M1 next --------
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    last_rd = 32'h0;
    @(negedge clk);
    m_address[0] = 32'h10; m_read[0] = 1'b1;
    m_address[1] = 32'h20; m_read[1] = 1'b1;
    got0 = -1; got1 = -1; cyc = 0;
    while ((got0 < 0 || got1 < 0) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (!m_waitrequest[0] && got0 < 0) begin
        got0 = cyc; m_read[0] = 1'b0;
        chk("tie m0 rdata", {32'd0, m_readdata}, {32'd0, ref_mem[4]});
      end
      if (!m_waitrequest[1] && got1 < 0) begin
        got1 = cyc; m_read[1] = 1'b0;
        chk("tie m1 rdata", {32'd0, m_readdata}, {32'd0, ref_mem[8]});
      end
    end
    chk("tie m0 cycle", 64'(got0), 64'd3);
    chk("tie m1 cycle", 64'(got1), 64'(3 + 4));
    model_last = 1;

    // -------- both masters requesting continuously --------
    @(negedge clk);
    m_read[0] = 1'b1; m_read[1] = 1'b1;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (m_waitrequest != 2'b11) begin
        order[n] = m_waitrequest[0] ? 1 : 0;
        chk("stream rdata", {32'd0, m_readdata},
            {32'd0, ref_mem[order[n] == 0 ? 4 : 8]});
        chk("stream cycle", 64'(cyc), 64'(3 + 4*n));
        n++;
      end
    end
    m_read = 2'b00;
    chk("stream count", 64'(n), 64'd4);
    for (int k = 0; k < 4; k++) begin
`ifdef MIPS_BUS_ARB_RR_EN
      exp_g = 1 - model_last;
`else
      exp_g = 0;
`endif
      model_last = exp_g;
      if (k < n) chk($sformatf("stream grant%0d", k), 64'(order[k]), 64'(exp_g));
    end
    last_rd = ref_mem[order[3] == 0 ? 4 : 8];

    // -------- reset during LAT --------
    @(negedge clk);
    m_address[0] = 32'h30; m_read[0] = 1'b1;
    @(negedge clk);   // ACCESS
    @(negedge clk);   // LAT
    chk("lat busy", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    chk("async rst", {60'd0, m_waitrequest, busy, s_read}, {60'd0, 2'b11, 1'b0, 1'b0});
    @(negedge clk);
    chk("rst next cycle", {60'd0, m_waitrequest, busy, s_read}, {60'd0, 2'b11, 1'b0, 1'b0});
    m_read[0] = 1'b0;
    reset = 1'b1;
    last_rd = 32'h0;
    do_txn(0, 1'b0, 1'b1, 32'h30, 32'h0, 4'hF, 0, 3, ref_mem[12], "post rst read");

    // -------- randomized single-master traffic against the model --------
    for (int i = 0; i < 40; i++) begin
      int          m, st;
      bit          wr, rd;
      logic [31:0] addr, wd;
      logic [3:0]  be;
      m    = int'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      rd   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      addr = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      wd   = $urandom;
      be   = 4'($urandom_range(0, 15));
      st   = int'($urandom_range(0, 2));
      exp_word = wr ? last_rd : ref_mem[addr[11:2]];
      do_txn(m, wr, rd, addr, wd, be, st, 2 + st + (wr ? 0 : RL), exp_word,
             $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mips_bus_arbiter
`default_nettype wire
